// File: rtl/mult_div_unit.sv
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add; DIV/DIVU use restoring shift-subtract. Both run in hi/lo.
module mult_div_unit #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO writes accepted
  // S_CALC | one multiply/divide iteration per edge, N edges
  // S_FIX  | sign correction, result written, done raised
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sgn;
  logic [N-1:0]       abs_a, abs_b;
  logic [N:0]         rem_sh, sum;
  logic [N-1:0]       diff;
  logic [2*N-1:0]     prod_neg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC);
  end

  // Signed ops work on magnitudes; signs are restored in S_FIX.
  assign sgn      = ~op[0];
  assign abs_a    = (sgn && inA[N-1]) ? (~inA + 1'b1) : inA;
  assign abs_b    = (sgn && inB[N-1]) ? (~inB + 1'b1) : inB;
  assign rem_sh   = {hi_q, lo_q[N-1]};
  assign diff     = rem_sh[N-1:0] - m_q;
  assign sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign prod_neg = ~{hi_q, lo_q} + 1'b1;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_wen) hi_d = wd;
        if (lo_wen) lo_d = wd;
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = sgn & (inA[N-1] ^ inB[N-1]);
          neg_rem_d = sgn & inA[N-1];
          dz_d      = op[1] & (inB == '0);
          cnt_d     = CNT_W'(N-1);
          hi_d      = '0;
          lo_d      = op[1] ? abs_a : abs_b;
          m_d       = op[1] ? abs_b : abs_a;
        end
      end
      S_CALC: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (is_div_q) begin
          if (rem_sh >= {1'b0, m_q}) begin
            hi_d = diff;
            lo_d = {lo_q[N-2:0], 1'b1};
          end else begin
            hi_d = rem_sh[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b0};
          end
        end else begin
          hi_d = sum[N:1];
          lo_d = {sum[0], lo_q[N-1:1]};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        dbz_d  = is_div_q & dz_q;
        if (is_div_q) begin
          // Division by zero leaves the dividend magnitude in hi, so only lo needs forcing.
          lo_d = dz_q ? '1 : (neg_res_q ? (~lo_q + 1'b1) : lo_q);
          hi_d = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
        end else if (neg_res_q) begin
          {hi_d, lo_d} = prod_neg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push expected hi/lo/flag,
// a negedge monitor pops and compares whenever done is presented.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] inA = '0, inB = '0, wd = '0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t exp_q[$];

  mult_div_unit #(.N(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .inA(inA), .inB(inB), .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: compares every done presentation against the scoreboard head.
  always @(negedge clock) begin
    if (reset) begin
      if (done) begin
        exp_t e;
        chk("busy_with_done", {31'b0, busy}, 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        end
      end else begin
        chk("dbz_without_done", {31'b0, div_by_zero}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input bit disturb);
    int lat;
    int busy_cnt;
    exp_t e;
    @(negedge clock);
    start = 1'b1; op = o; inA = a; inB = b;
    e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (disturb && lat == 5) begin
        start = 1'b1; op = 2'b00; inA = 32'd123; inB = 32'd456;
        hi_wen = 1'b1; wd = 32'h1234;
      end
      if (disturb && lat == 7) begin
        start = 1'b0; hi_wen = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    if (lat >= 100) begin
      checks++; errors++;
      $display("FAIL timeout_waiting_done actual=%0d required=33", lat);
    end else begin
      chk("latency", lat, 32'd33);
      chk("busy_cycles", busy_cnt, 32'd32);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clock); reset = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 1'b0);
    issue(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0);

    // DIVU 100/7 with a start and MTHI thrown at it mid-operation.
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    @(negedge clock);
    lo_wen = 1'b1; wd = 32'h0000_ABCD;
    @(posedge clock); #1;
    lo_wen = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mtlo_hi_held", hi, 32'd2);
    repeat (3) @(posedge clock);
    #1;
    chk("hold_lo", lo, 32'h0000_ABCD);

    // Abort a DIV at iteration 10 with reset; no done may follow.
    @(negedge clock);
    start = 1'b1; op = 2'b10; inA = 32'd1000; inB = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (40) @(posedge clock);

    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
